// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 round sequencer: FSM state type,
// op trace encoding, one-hot load selects and block geometry.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_BLOCK_W    = 128;
    localparam logic [3:0] AES_LAST_ROUND = 4'(AES_NUM_ROUNDS);

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_ARK   = 3'd1,
        SEQ_SUB   = 3'd2,
        SEQ_SHIFT = 3'd3,
        SEQ_MIX   = 3'd4,
        SEQ_DONE  = 3'd5
    } aes_seq_state_t;

    localparam logic [1:0] AES_OP_SUB   = 2'd0;
    localparam logic [1:0] AES_OP_SHIFT = 2'd1;
    localparam logic [1:0] AES_OP_MIX   = 2'd2;
    localparam logic [1:0] AES_OP_ARK   = 2'd3;

    // One-hot select for the state register input mux; all-zero means hold.
    localparam logic [4:0] AES_LD_NONE  = 5'b00000;
    localparam logic [4:0] AES_LD_IN    = 5'b00001;
    localparam logic [4:0] AES_LD_SUB   = 5'b00010;
    localparam logic [4:0] AES_LD_SHIFT = 5'b00100;
    localparam logic [4:0] AES_LD_MIX   = 5'b01000;
    localparam logic [4:0] AES_LD_ARK   = 5'b10000;

    function automatic logic [1:0] aes_op_for_state(input aes_seq_state_t st);
        case (st)
            SEQ_SUB:   return AES_OP_SUB;
            SEQ_SHIFT: return AES_OP_SHIFT;
            SEQ_MIX:   return AES_OP_MIX;
            default:   return AES_OP_ARK;
        endcase
    endfunction

endpackage

// File: rtl/aes_seq_fsm.sv
// Round/transform sequencing FSM: owns the state, the round counter, the
// handshake and trace outputs, and drives the one-hot load select of the top.
module aes_seq_fsm
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       busy,
    output logic [3:0] ark_sel,
    output logic [1:0] op,
`ifdef AES_SEQ_STATS_EN
    output logic       done_hs,
`endif
    output logic [4:0] load_sel
);

    aes_seq_state_t state_r;
    aes_seq_state_t state_nxt_s;
    logic [3:0]     round_r;
    logic [3:0]     round_nxt_s;
    logic [4:0]     load_sel_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           busy_r;
    logic [3:0]     ark_sel_r;
    logic [1:0]     op_r;

    // Next-state, round and load-select decode.
    always_comb begin
        state_nxt_s = state_r;
        round_nxt_s = round_r;
        load_sel_s  = AES_LD_NONE;
        if (round_r > AES_LAST_ROUND) begin
            state_nxt_s = SEQ_IDLE;
            round_nxt_s = 4'd0;
        end else begin
            case (state_r)
                SEQ_IDLE: begin
                    round_nxt_s = 4'd0;
                    if (in_valid) begin
                        load_sel_s  = AES_LD_IN;
                        state_nxt_s = SEQ_ARK;
                    end else begin
                        state_nxt_s = SEQ_IDLE;
                    end
                end
                SEQ_ARK: begin
                    load_sel_s = AES_LD_ARK;
                    if (round_r == AES_LAST_ROUND) begin
                        state_nxt_s = SEQ_DONE;
                    end else begin
                        round_nxt_s = round_r + 4'd1;
                        state_nxt_s = SEQ_SUB;
                    end
                end
                SEQ_SUB: begin
                    load_sel_s  = AES_LD_SUB;
                    state_nxt_s = SEQ_SHIFT;
                end
                SEQ_SHIFT: begin
                    load_sel_s = AES_LD_SHIFT;
                    // The final round has no MixColumns.
                    if (round_r == AES_LAST_ROUND) begin
                        state_nxt_s = SEQ_ARK;
                    end else begin
                        state_nxt_s = SEQ_MIX;
                    end
                end
                SEQ_MIX: begin
                    load_sel_s  = AES_LD_MIX;
                    state_nxt_s = SEQ_ARK;
                end
                SEQ_DONE: begin
                    if (out_ready) begin
                        state_nxt_s = SEQ_IDLE;
                    end else begin
                        state_nxt_s = SEQ_DONE;
                    end
                end
                default: begin
                    state_nxt_s = SEQ_IDLE;
                    round_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State, round counter and outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= SEQ_IDLE;
            round_r     <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ark_sel_r   <= 4'd0;
            op_r        <= AES_OP_ARK;
        end else begin
            state_r     <= state_nxt_s;
            round_r     <= round_nxt_s;
            in_ready_r  <= (state_nxt_s == SEQ_IDLE);
            out_valid_r <= (state_nxt_s == SEQ_DONE);
            busy_r      <= (state_nxt_s != SEQ_IDLE);
            ark_sel_r   <= (state_nxt_s == SEQ_IDLE) ? 4'd0 : round_nxt_s;
            op_r        <= aes_op_for_state(state_nxt_s);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign ark_sel   = ark_sel_r;
    assign op        = op_r;
    assign load_sel  = load_sel_s;

`ifdef AES_SEQ_STATS_EN
    assign done_hs = (state_r == SEQ_DONE) && out_ready && (round_r <= AES_LAST_ROUND);
`endif

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: 128-bit state register, 5-way load
// mux and sequencing FSM. Optional AES_SEQ_STATS_EN adds a blocks_done counter.
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy,
    output logic [AES_BLOCK_W-1:0] xform_state,
    input  logic [AES_BLOCK_W-1:0] sub_result,
    input  logic [AES_BLOCK_W-1:0] shift_result,
    input  logic [AES_BLOCK_W-1:0] mix_result,
    input  logic [AES_BLOCK_W-1:0] ark_result,
    output logic [3:0]             ark_sel,
    output logic [1:0]             op
`ifdef AES_SEQ_STATS_EN
    ,
    output logic [15:0]            blocks_done
`endif
);

    logic [AES_BLOCK_W-1:0] state_r;
    logic [AES_BLOCK_W-1:0] state_nxt_s;
    logic [4:0]             load_sel_s;
`ifdef AES_SEQ_STATS_EN
    logic                   done_hs_s;
    logic [15:0]            blocks_done_r;
`endif

    aes_seq_fsm u_fsm (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .ark_sel   (ark_sel),
        .op        (op),
`ifdef AES_SEQ_STATS_EN
        .done_hs   (done_hs_s),
`endif
        .load_sel  (load_sel_s)
    );

    // State register input mux; no select leaves the ciphertext in place.
    always_comb begin
        state_nxt_s = state_r;
        case (load_sel_s)
            AES_LD_IN:    state_nxt_s = in_data;
            AES_LD_SUB:   state_nxt_s = sub_result;
            AES_LD_SHIFT: state_nxt_s = shift_result;
            AES_LD_MIX:   state_nxt_s = mix_result;
            AES_LD_ARK:   state_nxt_s = ark_result;
            default:      state_nxt_s = state_r;
        endcase
    end

    // The AES state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= {AES_BLOCK_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign xform_state = state_r;
    assign out_data    = state_r;

`ifdef AES_SEQ_STATS_EN
    // Completed-block counter, wraps naturally at 16 bits.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            blocks_done_r <= 16'd0;
        end else if (done_hs_s) begin
            blocks_done_r <= blocks_done_r + 16'd1;
        end else begin
            blocks_done_r <= blocks_done_r;
        end
    end

    assign blocks_done = blocks_done_r;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: attaches behavioural AES transform stages and
// compares each block against a whole-cipher reference plus timing/trace rules.
module tb_aes_round_sequencer;

    logic         Clk;
    logic         Reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [127:0] xform_state;
    logic [127:0] sub_result;
    logic [127:0] shift_result;
    logic [127:0] mix_result;
    logic [127:0] ark_result;
    logic [3:0]   ark_sel;
    logic [1:0]   op;
`ifdef AES_SEQ_STATS_EN
    logic [15:0]  blocks_done;
    int           exp_blocks;
`endif

    logic [127:0] cur_key;
    logic [127:0] last_ct;
    time          last_acc_t;
    int           n_vec;
    int           n_err;

    aes_round_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .xform_state  (xform_state),
        .sub_result   (sub_result),
        .shift_result (shift_result),
        .mix_result   (mix_result),
        .ark_result   (ark_result),
        .ark_sel      (ark_sel),
`ifdef AES_SEQ_STATS_EN
        .blocks_done  (blocks_done),
`endif
        .op           (op)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r = 8'h01;
        logic [7:0] p = b;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] rnd);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          k;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        k = 4 * int'(rnd);
        return {w[k], w[k+1], w[k+2], w[k+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ round_key(key, 4'd0);
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ round_key(key, 4'(r));
        return shift_rows(sub_bytes(s)) ^ round_key(key, 4'd10);
    endfunction

    // Combinational transform stages attached beside the sequencer.
    always_comb begin
        sub_result   = sub_bytes(xform_state);
        shift_result = shift_rows(xform_state);
        mix_result   = mix_columns(xform_state);
        ark_result   = xform_state ^ round_key(cur_key, ark_sel);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  128'(in_ready),  128'd1);
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check_eq({tag, "_busy"},      128'(busy),      128'd0);
        check_eq({tag, "_ark_sel"},   128'(ark_sel),   128'd0);
        check_eq({tag, "_op"},        128'(op),        128'd3);
        check_eq({tag, "_out_data"},  out_data,        128'd0);
        check_eq({tag, "_xform"},     xform_state,     128'd0);
`ifdef AES_SEQ_STATS_EN
        check_eq({tag, "_blocks"},    128'(blocks_done), 128'd0);
`endif
    endtask

    // Runs one block from an idle negedge; returns at the negedge after the
    // output handshake (or after the mid-block reset when abort_at is non-zero).
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int hold,
                             input bit pulses, input int abort_at, input bit chk_interval);
        logic [127:0] exp_ct;
        logic [79:0]  ops, exp_ops;
        logic [43:0]  arks, exp_arks;
        logic [127:0] held;
        bit           stable;
        int           lat, upd;
        time          acc_t;

        exp_ct = aes_ref(pt, key);
        exp_ops = '0;
        exp_ops = {exp_ops[77:0], 2'd3};
        for (int r = 1; r <= 10; r++) begin
            exp_ops = {exp_ops[77:0], 2'd0};
            exp_ops = {exp_ops[77:0], 2'd1};
            if (r != 10) exp_ops = {exp_ops[77:0], 2'd2};
            exp_ops = {exp_ops[77:0], 2'd3};
        end
        exp_arks = '0;
        for (int r = 0; r <= 10; r++) exp_arks = {exp_arks[39:0], 4'(r)};

        cur_key = key;
        check_eq("idle_in_ready", 128'(in_ready), 128'd1);
        in_data  = pt;
        in_valid = 1'b1;
        @(posedge Clk);
        acc_t = $time;
        if (chk_interval) check_eq("issue_interval", 128'((acc_t - last_acc_t) / 10), 128'd42);
        last_acc_t = acc_t;

        ops = '0; arks = '0; lat = 0; upd = 0;
        do begin
            @(negedge Clk);
            lat++;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            if (pulses && (lat == 5 || lat == 30)) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (pulses && lat >= 10 && lat < 13) out_ready = 1'b1;
            if (abort_at != 0 && lat == abort_at) begin
                Reset_n = 1'b0;
                @(negedge Clk);
                check_reset_outputs("midreset");
                Reset_n  = 1'b1;
                in_valid = 1'b0;
                out_ready = 1'b0;
`ifdef AES_SEQ_STATS_EN
                exp_blocks = 0;
`endif
                return;
            end
            if (!out_valid && busy) begin
                upd++;
                ops = {ops[77:0], op};
                if (op == 2'd3) arks = {arks[39:0], ark_sel};
            end
        end while (!out_valid && lat < 60);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        check_eq("out_valid_seen", 128'(out_valid), 128'd1);
        check_eq("latency", 128'(lat), 128'd41);
        check_eq("update_cycles", 128'(upd), 128'd40);
        check_eq("op_trace", 128'(ops), 128'(exp_ops));
        check_eq("ark_sel_trace", 128'(arks), 128'(exp_arks));
        check_eq("ciphertext", out_data, exp_ct);
        last_ct = out_data;

        held = out_data;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) check_eq("backpressure_hold", 128'(stable), 128'd1);

        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
`ifdef AES_SEQ_STATS_EN
        exp_blocks = (exp_blocks + 1) % 65536;
        check_eq("blocks_done", 128'(blocks_done), 128'(exp_blocks));
`endif
        check_eq("post_hs_in_ready", 128'(in_ready), 128'd1);
        check_eq("post_hs_out_valid", 128'(out_valid), 128'd0);
        check_eq("ct_retained", out_data, exp_ct);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        cur_key   = '0;
        last_ct   = '0;
        last_acc_t = 0;
`ifdef AES_SEQ_STATS_EN
        exp_blocks = 0;
`endif
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Reset_n = 1'b1;

        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  20, 1'b0, 0, 1'b0);
        check_eq("fips197_ct", last_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  0, 1'b1, 0, 1'b0);

        for (int b = 0; b < 3; b++)
            run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                      0, 1'b0, 0, b != 0);

        run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  0, 1'b0, 17, 1'b0);
        run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  0, 1'b0, 0, 1'b0);

        for (int b = 0; b < 4; b++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 5)), 1'(b % 2), 0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
